// File: rtl/uart_if.sv
// uart_if: transmit/receive word streams between a client and uart_core.
interface uart_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] tx_data, rx_data;
  logic tx_valid, tx_ready, rx_valid, rx_frame_err, rx_parity_err;
  modport master(output tx_data, tx_valid, input tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err);
  modport slave(input tx_data, tx_valid, output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err);
endinterface

// File: rtl/uart_core.sv
// uart_core: oversampling UART receiver and bit-timed transmitter.
// Define UART_PARITY_EN to add one even-parity bit after the data bits.
module uart_core #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD = 9600,
  parameter int DATA_BITS = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic txd,
  uart_if.slave bus
);
  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int BIT_CYC = DIV * OVERSAMPLE;
  localparam int CW = $clog2(BIT_CYC + 1);
  localparam int DW = $clog2(DIV + 1);
  localparam int OW = $clog2(OVERSAMPLE);
`ifdef UART_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  generate
    if (DIV < 1) begin : g_bad_div
      $error("uart_core: CLK_HZ too low for BAUD*OVERSAMPLE");
    end
  endgenerate
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} st_t;
  st_t tx_st, tx_nxt, rx_st, rx_nxt;
  logic [CW-1:0] tx_cnt;
  logic [DATA_BITS-1:0] tx_sh, rx_sh;
  logic [3:0] tx_idx, rx_idx;
  logic tx_par, tx_end, tx_last, tx_load;
  assign tx_end = tx_cnt == CW'(BIT_CYC - 1);
  assign tx_last = tx_idx == 4'(DATA_BITS - 1);
  // a frame still held valid at the end of STOP starts immediately, no idle bit
  assign tx_load = bus.tx_valid && (tx_st == IDLE || (tx_st == STOP && tx_end));
  assign bus.tx_ready = tx_st == IDLE;
  assign txd = tx_st == START ? 1'b0 : tx_st == DATA ? tx_sh[0] : tx_st == PARITY ? tx_par : 1'b1;
  always_comb begin
    tx_nxt = tx_st;
    case (tx_st)
      IDLE:    tx_nxt = bus.tx_valid ? START : IDLE;
      START:   tx_nxt = tx_end ? DATA : START;
      DATA:    tx_nxt = tx_end && tx_last ? (PAR ? PARITY : STOP) : DATA;
      PARITY:  tx_nxt = tx_end ? STOP : PARITY;
      STOP:    tx_nxt = tx_end ? (bus.tx_valid ? START : IDLE) : STOP;
      default: tx_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st <= IDLE;
      tx_cnt <= '0;
      tx_sh <= '0;
      tx_idx <= '0;
      tx_par <= 1'b0;
    end else begin
      tx_st <= tx_nxt;
      tx_cnt <= (tx_load || tx_end || tx_st == IDLE) ? '0 : tx_cnt + 1'b1;
      if (tx_load) begin
        tx_sh <= bus.tx_data;
        tx_idx <= '0;
        tx_par <= ^bus.tx_data;
      end else if (tx_st == DATA && tx_end) begin
        tx_sh <= tx_sh >> 1;
        tx_idx <= tx_idx + 1'b1;
      end
    end
  end
  logic rx_m, rx_s, rx_d, rx_par, tick, rx_mid, rx_fall, rx_last;
  logic [DW-1:0] div_cnt;
  logic [OW-1:0] os_cnt;
  assign tick = div_cnt == DW'(DIV - 1);
  // the oversample counter free-runs through the frame, so every bit is sampled at the same phase
  assign rx_mid = rx_st != IDLE && tick && os_cnt == OW'(OVERSAMPLE / 2 - 1);
  assign rx_fall = rx_d & ~rx_s;
  assign rx_last = rx_idx == 4'(DATA_BITS - 1);
  always_comb begin
    rx_nxt = rx_st;
    case (rx_st)
      IDLE:    rx_nxt = rx_fall ? START : IDLE;
      START:   rx_nxt = rx_mid ? (rx_s ? IDLE : DATA) : START;
      DATA:    rx_nxt = rx_mid && rx_last ? (PAR ? PARITY : STOP) : DATA;
      PARITY:  rx_nxt = rx_mid ? STOP : PARITY;
      STOP:    rx_nxt = rx_mid ? IDLE : STOP;
      default: rx_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {rx_m, rx_s, rx_d} <= 3'b111;
      rx_st <= IDLE;
      div_cnt <= '0;
      os_cnt <= '0;
      rx_sh <= '0;
      rx_idx <= '0;
      rx_par <= 1'b0;
      bus.rx_data <= '0;
      bus.rx_valid <= 1'b0;
      bus.rx_frame_err <= 1'b0;
      bus.rx_parity_err <= 1'b0;
    end else begin
      {rx_m, rx_s, rx_d} <= {rxd, rx_m, rx_s};
      rx_st <= rx_nxt;
      div_cnt <= (rx_st == IDLE || tick) ? '0 : div_cnt + 1'b1;
      os_cnt <= rx_st == IDLE ? '0 : tick ? os_cnt + 1'b1 : os_cnt;
      bus.rx_valid <= rx_mid && rx_st == STOP;
      if (rx_st == IDLE) rx_idx <= '0;
      if (rx_mid && rx_st == DATA) begin
        rx_sh <= {rx_s, rx_sh[DATA_BITS-1:1]};
        rx_idx <= rx_idx + 1'b1;
      end
      if (rx_mid && rx_st == PARITY) rx_par <= rx_s;
      if (rx_mid && rx_st == STOP) begin
        bus.rx_data <= rx_sh;
        bus.rx_frame_err <= ~rx_s;
        bus.rx_parity_err <= PAR & (^rx_sh ^ rx_par);
      end
    end
  end
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed checks of uart_core TX timing, loopback RX, false start, framing/parity errors, reset.
`timescale 1ns/1ps
module tb_uart_core;
  localparam int DB = 8;
  localparam int BC = 64;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = DB + 2 + PB;
  logic clk = 1'b0, rst = 1'b1, rxd_drv = 1'b1, loop = 1'b0;
  logic rxd, txd;
  uart_if #(.DATA_BITS(DB)) bus();
  assign rxd = loop ? txd : rxd_drv;
  uart_core #(.CLK_HZ(614400), .BAUD(9600), .DATA_BITS(DB), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .txd(txd), .bus(bus)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0, cyc = 0, np = 0;
  logic [DB-1:0] pd[4];
  logic pf[4], pp[4];
  int pt[4];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.rx_valid) begin
    if (np < 4) begin
      pd[np] = bus.rx_data;
      pf[np] = bus.rx_frame_err;
      pp[np] = bus.rx_parity_err;
      pt[np] = cyc;
    end
    np++;
  end
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic fbit(logic [DB-1:0] d, int i, logic par, logic stop);
    return i == 0 ? 1'b0 : i <= DB ? d[i-1] : (PB == 1 && i == DB + 1) ? par : stop;
  endfunction
  task automatic tx_check(logic [DB-1:0] d);
    int bad[NB] = '{default: 0};
    int lowc = 0, idle_bad = 0;
    @(negedge clk);
    bus.tx_data = d;
    bus.tx_valid = 1'b1;
    for (int k = 0; k < NB * BC + 60; k++) begin
      @(negedge clk);
      if (k == 0) bus.tx_valid = 1'b0;
      if (!bus.tx_ready) lowc++;
      if (k < NB * BC) begin
        if (txd !== fbit(d, k / BC, ^d, 1'b1)) bad[k / BC]++;
      end else if (txd !== 1'b1) idle_bad++;
    end
    for (int i = 0; i < NB; i++) check($sformatf("tx %h bit%0d", d, i), bad[i], 0);
    check("tx_ready low cycles", lowc, NB * BC);
    check("txd idle after stop", idle_bad, 0);
  endtask
  task automatic rx_inject(logic [DB-1:0] d, logic par, logic stop);
    for (int i = 0; i < NB; i++) begin
      rxd_drv = fbit(d, i, par, stop);
      repeat (BC) @(negedge clk);
    end
    rxd_drv = 1'b1;
    repeat (BC) @(negedge clk);
  endtask
  task automatic wait_pulses(int n, int budget);
    for (int i = 0; i < budget && np < n; i++) @(negedge clk);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data = '0;
    repeat (3) @(negedge clk);
    check("reset txd", txd, 1);
    check("reset tx_ready", bus.tx_ready, 1);
    check("reset rx_valid", bus.rx_valid, 0);
    check("reset rx_data", bus.rx_data, 0);
    check("reset frame_err", bus.rx_frame_err, 0);
    check("reset parity_err", bus.rx_parity_err, 0);
    rst = 1'b0;
    @(negedge clk);
    tx_check(8'hA5);
    tx_check(8'h07);
    loop = 1'b1;
    np = 0;
    bus.tx_data = 8'h3C;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    check("tx_ready drop", bus.tx_ready, 0);
    bus.tx_data = 8'hC3;
    repeat (NB * BC + 50) @(negedge clk);
    bus.tx_valid = 1'b0;
    wait_pulses(2, 3000);
    check("loop pulse count", np, 2);
    check("loop data0", pd[0], 8'h3C);
    check("loop data1", pd[1], 8'hC3);
    check("loop ferr0", pf[0], 0);
    check("loop ferr1", pf[1], 0);
    check("loop spacing", pt[1] - pt[0], NB * BC);
    repeat (200) @(negedge clk);
    loop = 1'b0;
    np = 0;
    rxd_drv = 1'b0;
    repeat (20) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch no rx_valid", np, 0);
    rx_inject(8'h55, 1'b0, 1'b0);
    wait_pulses(1, 200);
    check("ferr pulse count", np, 1);
    check("ferr data", pd[0], 8'h55);
    check("ferr flag", pf[0], 1);
    check("ferr parity flag", pp[0], 0);
`ifdef UART_PARITY_EN
    np = 0;
    rx_inject(8'h07, 1'b0, 1'b1);
    wait_pulses(1, 200);
    check("perr pulse count", np, 1);
    check("perr data", pd[0], 8'h07);
    check("perr flag", pp[0], 1);
    check("perr frame flag", pf[0], 0);
`endif
    loop = 1'b1;
    np = 0;
    bus.tx_data = 8'h5A;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (200) @(negedge clk);
    check("busy before reset", bus.tx_ready, 0);
    rst = 1'b1;
    #1;
    check("reset txd async", txd, 1);
    check("reset rx_valid async", bus.rx_valid, 0);
    check("reset rx_data async", bus.rx_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("tx_ready after release", bus.tx_ready, 1);
    repeat (1500) @(negedge clk);
    check("aborted frame no rx_valid", np, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
